spi_channel_arbiter: RTL and testbench

//  Shares the single spiword SPI shifter between NREQ requesters, e.g. command FSM plus housekeeping DAC writes.

---
 rtl/spi_channel_arbiter_pkg.sv | 23 ++
 rtl/spi_channel_arbiter_rr_pick.sv | 37 +++
 rtl/spi_channel_arbiter.sv | 128 ++++++++++++
 tb/tb_spi_channel_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_channel_arbiter_pkg.sv
// Shared definitions for the SPI channel arbiter: frame width, state encodings,
// chip-select idle level and a width helper for small counters and pointers.
package spi_channel_arbiter_pkg;

  // Frame width of the spiword shifter this arbiter feeds.
  localparam int SPI_WORD_W = 24;

  // Chip selects are active low; this is the deasserted level.
  localparam logic CSN_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // $clog2 with a floor of 1 bit, so degenerate parameter values still give
  // a legal vector width.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_channel_arbiter_rr_pick.sv
// Round-robin winner selection: the first set request bit at or after the
// pointer, wrapping past NREQ-1. Purely combinational.
module spi_channel_arbiter_rr_pick
  import spi_channel_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  logic [2*NREQ-1:0] doubled;
  logic [NREQ-1:0]   rot;

  // Rotate the request vector so the pointer position lands at bit 0, then
  // take the lowest set bit and map it back to a channel index.
  always_comb begin
    int sum;
    winner  = '0;
    valid   = 1'b0;
    sum     = 0;
    doubled = {req, req};
    rot     = NREQ'(doubled >> ptr);
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        winner = PTR_W'(sum);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_channel_arbiter.sv
// Shares one spiword SPI shifter between NREQ requesters. Grants round-robin,
// drives the per-channel chip selects and the start strobe into spiword, and
// holds all chip selects high for a minimum gap between frames.
//
// Handshake: req[i] is a level "valid" held by the requester; ack[i] is the
// one-cycle accept pulse. word_i for channel i is latched on the edge that
// raises ack[i], after which the requester may drop req[i] or change its word.
// Dropping req[i] before ack[i] withdraws the request without side effects.
module spi_channel_arbiter
  import spi_channel_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WORD_W = SPI_WORD_W,
  parameter int GAP    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WORD_W-1:0] word_i,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      csn,
  output logic                 spi_we,
  output logic [WORD_W-1:0]    spi_tx,
  input  logic                 spi_running,
  output logic                 busy,
  output arb_state_t           state_dbg
);

  localparam int PTR_W = width_min1(NREQ);
  localparam int CNT_W = width_min1(GAP + 1);

  arb_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [CNT_W-1:0]  gap_cnt;
  logic [PTR_W-1:0]  pick_w;
  logic              pick_v;
  logic [PTR_W-1:0]  ptr_next;
  logic [WORD_W-1:0] words [NREQ];

  assign state_dbg = state;

  spi_channel_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_w),
    .valid  (pick_v)
  );

  // Unpack the flat per-channel word bus and work out where the pointer goes
  // after a grant (one past the winner, wrapping at NREQ-1).
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = word_i[i*WORD_W +: WORD_W];
    end
    ptr_next = (pick_w == PTR_W'(NREQ - 1)) ? '0 : pick_w + PTR_W'(1);
  end

  // Arbitration FSM. ack/done/spi_we are single-cycle pulses, so they default
  // low every cycle and are raised only on the transition that owns them.
  // A frame ends only once the strobe has been seen by spiword (spi_we low)
  // and spiword reports it is no longer running.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      owner   <= '0;
      gap_cnt <= '0;
      csn     <= {NREQ{CSN_IDLE}};
      ack     <= '0;
      done    <= '0;
      spi_we  <= 1'b0;
      spi_tx  <= '0;
      busy    <= 1'b0;
    end else begin
      ack    <= '0;
      done   <= '0;
      spi_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          // spiword has no reset, so a frame left running across our reset
          // must finish before anything new is started.
          if (pick_v && !spi_running) begin
            ack    <= NREQ'(1) << pick_w;
            csn    <= ~(NREQ'(1) << pick_w);
            spi_we <= 1'b1;
            spi_tx <= words[pick_w];
            ptr    <= ptr_next;
            owner  <= pick_w;
            busy   <= 1'b1;
            state  <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!spi_we && !spi_running) begin
            csn  <= {NREQ{CSN_IDLE}};
            done <= NREQ'(1) << owner;
            if (GAP == 0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              gap_cnt <= CNT_W'(GAP - 1);
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        default: begin
          csn   <= {NREQ{CSN_IDLE}};
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_channel_arbiter.sv
// Directed bench for spi_channel_arbiter. Two instances: "a" with GAP=4 for
// most scenarios, "b" with GAP=0 for the back-to-back period. Each instance
// drives a small behavioural spiword model (24-bit shifter, no reset).
module tb_spi_channel_arbiter;
  import spi_channel_arbiter_pkg::*;

  localparam int NREQ  = 2;
  localparam int W     = 24;
  localparam int A_GAP = 4;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT a (GAP=4) ----------------
  logic [NREQ-1:0]   a_req, a_ack, a_done, a_csn;
  logic [NREQ*W-1:0] a_word;
  logic              a_we, a_run, a_busy;
  logic [W-1:0]      a_tx;
  arb_state_t        a_st;

  spi_channel_arbiter #(.NREQ(NREQ), .WORD_W(W), .GAP(A_GAP)) u_dut_a (
    .clk(clk), .resetn(resetn), .req(a_req), .word_i(a_word), .ack(a_ack),
    .done(a_done), .csn(a_csn), .spi_we(a_we), .spi_tx(a_tx),
    .spi_running(a_run), .busy(a_busy), .state_dbg(a_st)
  );

  // ---------------- DUT b (GAP=0) ----------------
  logic [NREQ-1:0]   b_req, b_ack, b_done, b_csn;
  logic [NREQ*W-1:0] b_word;
  logic              b_we, b_run, b_busy;
  logic [W-1:0]      b_tx;
  arb_state_t        b_st;

  spi_channel_arbiter #(.NREQ(NREQ), .WORD_W(W), .GAP(0)) u_dut_b (
    .clk(clk), .resetn(resetn), .req(b_req), .word_i(b_word), .ack(b_ack),
    .done(b_done), .csn(b_csn), .spi_we(b_we), .spi_tx(b_tx),
    .spi_running(b_run), .busy(b_busy), .state_dbg(b_st)
  );

  // ---------------- spiword models ----------------
  logic         m_we  [2];
  logic [W-1:0] m_tx  [2];
  logic         m_run [2] = '{1'b0, 1'b0};
  logic [W-1:0] m_sh  [2] = '{'0, '0};
  logic [W-1:0] m_rx  [2] = '{'0, '0};
  int           m_cnt [2] = '{0, 0};

  assign m_we[0] = a_we;
  assign m_we[1] = b_we;
  assign m_tx[0] = a_tx;
  assign m_tx[1] = b_tx;
  assign a_run   = m_run[0];
  assign b_run   = m_run[1];

  // MSB-first shifter: running rises the edge after we, then 24 shift edges;
  // m_rx collects what went out on MOSI.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_run[m]) begin
        m_rx[m]  <= {m_rx[m][W-2:0], m_sh[m][W-1]};
        m_sh[m]  <= m_sh[m] << 1;
        m_cnt[m] <= m_cnt[m] - 1;
        if (m_cnt[m] == 1) m_run[m] <= 1'b0;
      end else if (m_we[m]) begin
        m_sh[m]  <= m_tx[m];
        m_rx[m]  <= '0;
        m_cnt[m] <= W;
        m_run[m] <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor for DUT a ----------------
  // Expected frames as {channel, word}, popped on each done pulse.
  logic [31:0] exp_q[$];
  int  high_run      = 0;
  bit  armed         = 0;
  bit  ack1_seen     = 0;
  bit  done_seen     = 0;
  bit  ack_while_run = 0;
  int  csn_bad       = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!resetn) begin
      high_run = 0;
      armed    = 0;
    end else begin
      check("a_csn_onehot", $countones(~a_csn) <= 1, 1'b1);
      check("b_csn_onehot", $countones(~b_csn) <= 1, 1'b1);
      if (a_done != '0) begin
        done_seen = 1;
        if (exp_q.size() == 0) begin
          check("frame_unexpected", {8'(a_done), m_rx[0]}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("frame", {8'(a_done[1]), m_rx[0]}, e);
        end
      end
      if (a_ack[1]) ack1_seen = 1;
      if (a_ack != '0 && a_run) ack_while_run = 1;
      if (a_csn == 2'b11) begin
        high_run++;
      end else begin
        if (armed && high_run > 0) check("csn_gap", high_run >= A_GAP, 1'b1);
        high_run = 0;
        armed    = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack_a(input int ch);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_ack[ch]) return;
    end
    check("ack_timeout", a_ack[ch], 1'b1);
  endtask

  task automatic wait_ack_a_any();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_ack != '0) return;
    end
    check("ack_any_timeout", a_ack != '0, 1'b1);
  endtask

  // Waits for done[ch]; counts cycles where csn is not the owner's pattern.
  task automatic wait_done_a(input int ch);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_done[ch]) return;
      if (a_csn != ~(2'b01 << ch)) csn_bad++;
    end
    check("done_timeout", a_done[ch], 1'b1);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!a_busy) return;
    end
    check("idle_timeout", a_busy, 1'b0);
  endtask

  task automatic wait_done_b(input int ch);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_done[ch]) return;
    end
    check("b_done_timeout", b_done[ch], 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_req  = '0;
    b_req  = '0;
    a_word = '0;
    b_word = '0;

    // Reset held with both requests up: nothing may be granted.
    resetn = 1'b0;
    a_req  = 2'b11;
    b_req  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_csn", a_csn, 2'b11);
      check("rst_ack", a_ack, 2'b00);
      check("rst_we", a_we, 1'b0);
      check("rst_busy", a_busy, 1'b0);
    end
    check("rst_state", a_st, ST_IDLE);
    check("rst_tx", a_tx, 24'h0);
    check("rst_b_csn", b_csn, 2'b11);
    a_req  = '0;
    b_req  = '0;
    resetn = 1'b1;
    tick(2);

    // Single frame on channel 0.
    a_word[23:0] = 24'h40ABC0;
    a_req[0]     = 1'b1;
    exp_q.push_back({8'd0, 24'h40ABC0});
    @(negedge clk);
    check("single_ack", a_ack, 2'b01);
    check("single_we", a_we, 1'b1);
    check("single_csn", a_csn, 2'b10);
    check("single_tx", a_tx, 24'h40ABC0);
    check("single_busy", a_busy, 1'b1);
    a_req[0] = 1'b0;
    csn_bad  = 0;
    wait_done_a(0);
    check("single_csn_hold", csn_bad, 0);
    check("single_done", a_done, 2'b01);
    check("single_csn_release", a_csn, 2'b11);
    check("single_mosi", m_rx[0], 24'h40ABC0);
    wait_idle_a();

    // Contention from a fresh pointer: grants alternate 0,1,0,1.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    a_word = {24'h222222, 24'h111111};
    for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? {8'd0, 24'h111111} : {8'd1, 24'h222222});
    a_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack_a_any();
      check("rr_grant", a_ack, 2'b01 << (k % 2));
      if (k == 3) a_req = 2'b00;
    end
    wait_idle_a();

    // Channel 1 pulses its request for one cycle while channel 0 is mid-frame.
    a_word[23:0] = 24'h0F0F0F;
    a_req[0]     = 1'b1;
    exp_q.push_back({8'd0, 24'h0F0F0F});
    wait_ack_a(0);
    a_req[0]  = 1'b0;
    tick(3);
    ack1_seen = 0;
    a_req[1]  = 1'b1;
    @(negedge clk);
    a_req[1]  = 1'b0;
    wait_done_a(0);
    wait_idle_a();
    tick(5);
    check("withdraw_no_ack1", ack1_seen, 1'b0);

    // Reset mid-frame with channel 1 pending.
    a_word[23:0] = 24'h5A5A5A;
    a_req[0]     = 1'b1;
    exp_q.push_back({8'd0, 24'h5A5A5A});
    wait_ack_a(0);
    a_req[0]      = 1'b0;
    tick(5);
    a_word[47:24] = 24'h0C0FFE;
    a_req[1]      = 1'b1;
    tick(1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_csn", a_csn, 2'b11);
    check("midrst_we", a_we, 1'b0);
    check("midrst_done", a_done, 2'b00);
    check("midrst_busy", a_busy, 1'b0);
    resetn = 1'b1;
    void'(exp_q.pop_back());
    exp_q.push_back({8'd1, 24'h0C0FFE});
    done_seen     = 0;
    ack_while_run = 0;
    for (int i = 0; i < 100; i++) begin
      if (!a_run) break;
      @(negedge clk);
    end
    check("midrst_run_fell", a_run, 1'b0);
    @(negedge clk);
    check("midrst_grant_after_run", a_ack, 2'b10);
    check("midrst_no_early_grant", ack_while_run, 1'b0);
    check("midrst_no_done", done_seen, 1'b0);
    a_req[1] = 1'b0;
    wait_done_a(1);
    wait_idle_a();

    // GAP=0 instance: held request restarts one cycle after done.
    b_word[47:24] = 24'hABCDEF;
    b_req[1]      = 1'b1;
    wait_done_b(1);
    check("gap0_done", b_done, 2'b10);
    check("gap0_csn_release", b_csn, 2'b11);
    check("gap0_mosi", m_rx[1], 24'hABCDEF);
    @(negedge clk);
    check("gap0_regrant_csn", b_csn, 2'b01);
    check("gap0_regrant_ack", b_ack, 2'b10);
    check("gap0_regrant_we", b_we, 1'b1);
    b_req[1] = 1'b0;
    wait_done_b(1);
    check("gap0_mosi2", m_rx[1], 24'hABCDEF);

    tick(5);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
